// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first subtractor d = a - b through one borrow flip-flop.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp negative results to zero (unsigned saturating subtract).
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  output logic             o_w_valid,
  input  logic             i_w_ready,
  output logic [WIDTH:0]   o_w_d,
  output logic             o_w_busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [CW-1:0] count;
  logic br, d_bit, br_nx, last;
  assign d_bit = a_q[0] ^ b_q[0] ^ br;
  assign br_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br);
  assign last  = count == CW'(WIDTH - 1);
  always_ff @(posedge i_w_clk or negedge i_w_rst_n)
    if (!i_w_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_w_valid ? SHIFT : IDLE;
      SHIFT:   state_nx = last ? DONE : SHIFT;
      DONE:    state_nx = i_w_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Operands shift right so the current bit is always at index 0; result fills from the MSB down.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n)
    if (!i_w_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      br    <= 1'b0;
      count <= '0;
    end else if (state == IDLE && i_w_valid) begin
      a_q   <= i_w_a;
      b_q   <= i_w_b;
      br    <= 1'b0;
      count <= '0;
    end else if (state == SHIFT) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      d_q   <= {d_bit, d_q[WIDTH-1:1]};
      br    <= br_nx;
      count <= count + 1'b1;
    end
  always_comb begin
    o_w_ready = state == IDLE;
    o_w_busy  = state == SHIFT;
    o_w_valid = state == DONE;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    o_w_d     = (state == DONE && !br) ? {br, d_q} : '0;
`else
    o_w_d     = state == DONE ? {br, d_q} : '0;
`endif
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, handshake corner cases, exhaustive sweep and random ops vs arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [5:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [6:0] d;
  int checks = 0, errors = 0;

  serial_subtractor #(.WIDTH(6)) dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(in_valid), .o_w_ready(in_ready),
    .i_w_a(a), .i_w_b(b), .o_w_valid(out_valid), .i_w_ready(out_ready),
    .o_w_d(d), .o_w_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [5:0] a; logic [5:0] b; logic [6:0] d_full; logic [6:0] d_sat;} vec_t;
  vec_t vecs[6];

  function automatic logic [6:0] model(input int ma, input int mb);
    int r;
    r = ma - mb;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (r < 0) r = 0;
`endif
    return 7'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents operands for one cycle, measures edges from accept (inclusive) to valid, then takes the result.
  task automatic run_op(input logic [5:0] oa, input logic [5:0] ob, output logic [6:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = oa; b = ob;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = d;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [6:0] res, held;
    int lat, sweep_err;
    vecs[0] = '{6'd5,  6'd3,  7'd2,       7'd0};
    vecs[1] = '{6'd3,  6'd5,  7'b1111110, 7'd0};
    vecs[2] = '{6'd0,  6'd63, 7'b1000001, 7'd0};
    vecs[3] = '{6'd63, 6'd0,  7'd63,      7'd0};
    vecs[4] = '{6'd42, 6'd42, 7'd0,       7'd0};
    vecs[5] = '{6'd10, 6'd1,  7'd9,       7'd0};
    vecs[0].d_sat = 7'd2; vecs[3].d_sat = 7'd63; vecs[5].d_sat = 7'd9;

    #12;
    check("reset_ready", 32'(in_ready), 1);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_d", 32'(d), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, lat);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      check($sformatf("vec%0d_d", i), 32'(res), 32'(vecs[i].d_sat));
`else
      check($sformatf("vec%0d_d", i), 32'(res), 32'(vecs[i].d_full));
`endif
      check($sformatf("vec%0d_latency", i), lat, 7);
    end

    // Backpressure: result held 20 cycles while a competing operand request is ignored.
    @(negedge clk);
    in_valid = 1'b1; a = 6'd50; b = 6'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && !out_valid; k++) @(posedge clk);
    #1;
    held = d;
    check("bp_first_d", 32'(held), 32'(model(50, 7)));
    in_valid = 1'b1; a = 6'd1; b = 6'd2;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_d", 32'(d), 32'(held));
      check("bp_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_ready", 32'(in_ready), 1);

    // Reset during the third shift cycle aborts the operation at once.
    @(negedge clk);
    in_valid = 1'b1; a = 6'd33; b = 6'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_d", 32'(d), 0);
    check("mid_rst_ready", 32'(in_ready), 1);
    @(negedge clk) rst_n = 1'b1;
    run_op(6'd10, 6'd1, res, lat);
    check("post_rst_d", 32'(res), 32'(model(10, 1)));

    sweep_err = 0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) begin
        run_op(6'(i), 6'(j), res, lat);
        if (res !== model(i, j) || lat != 7) begin
          sweep_err++;
          if (sweep_err <= 10) check($sformatf("sweep_%0d_%0d", i, j), 32'(res), 32'(model(i, j)));
        end
      end
    check("sweep_mismatches", sweep_err, 0);

    for (int k = 0; k < 200; k++) begin
      int ra, rb;
      ra = int'($urandom_range(63));
      rb = int'($urandom_range(63));
      run_op(6'(ra), 6'(rb), res, lat);
      check($sformatf("rand_%0d_%0d", ra, rb), 32'(res), 32'(model(ra, rb)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
